// File: rtl/pipeline_barrier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared types and constants for the inter-stage pipeline barrier.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } barrier_action_e;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

    // Priority is flush > stall > bubble > advance.
    function automatic barrier_action_e decodeAction(
        input logic flush,
        input logic stall,
        input logic insertBubble
    );
        if (flush)             return ACT_FLUSH;
        else if (stall)        return ACT_HOLD;
        else if (insertBubble) return ACT_BUBBLE;
        else                   return ACT_ADVANCE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_barrier_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_barrier_if
// Brief    : Hazard controls, upstream payload and status bundle of a barrier.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_barrier_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 1,
    parameter int COUNTER_WIDTH = 16
);
    localparam int c_OCC_WIDTH = $clog2(DEPTH + 1);

    logic                     stall;
    logic                     flush;
    logic                     insertBubble;
    logic                     inValid;
    logic [DATA_WIDTH-1:0]    inData;
    logic                     outValid;
    logic [DATA_WIDTH-1:0]    outData;
    logic [c_OCC_WIDTH-1:0]   occupancy;
    logic [COUNTER_WIDTH-1:0] stallCount;
    logic [COUNTER_WIDTH-1:0] bubbleCount;

    modport master (
        output stall, flush, insertBubble, inValid, inData,
        input  outValid, outData, occupancy, stallCount, bubbleCount
    );

    modport slave (
        input  stall, flush, insertBubble, inValid, inData,
        output outValid, outData, occupancy, stallCount, bubbleCount
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_barrier_stage.sv
`default_nettype none
// ============================================================================
// Module   : barrier_stage
// Brief    : One {valid,payload} register of the barrier, steered by the action.
// Revision : 1.0 - initial release
// ============================================================================
module barrier_stage
    import pipeline_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter bit                    IS_HEAD      = 1'b0
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire barrier_action_e       action,
    input  wire logic                  prevValid,
    input  wire logic [DATA_WIDTH-1:0] prevData,
    output logic                       valid,
    output logic [DATA_WIDTH-1:0]      data
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // Only the head stage turns a bubble request into a NOP; later stages keep shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE_VALUE;
        end else begin
            case (action)
                ACT_FLUSH: begin
                    r_valid <= 1'b0;
                    r_data  <= BUBBLE_VALUE;
                end
                ACT_HOLD: begin
                    r_valid <= r_valid;
                    r_data  <= r_data;
                end
                ACT_BUBBLE: begin
                    if (IS_HEAD) begin
                        r_valid <= 1'b0;
                        r_data  <= BUBBLE_VALUE;
                    end else begin
                        r_valid <= prevValid;
                        r_data  <= prevData;
                    end
                end
                default: begin
                    r_valid <= prevValid;
                    r_data  <= prevData;
                end
            endcase
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipeline_barrier.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_barrier
// Brief    : DEPTH-stage inter-stage register with stall/flush/bubble control
//            and saturating stall/bubble performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_barrier
    import pipeline_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    DEPTH         = 1,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE  = '0,
    parameter int                    COUNTER_WIDTH = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pipeline_barrier_if.slave bus
);

    localparam int c_OCC_WIDTH = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 1) begin : g_badDepth
            $error("pipeline_barrier: DEPTH must be at least 1");
        end
        if (DATA_WIDTH < 1) begin : g_badWidth
            $error("pipeline_barrier: DATA_WIDTH must be at least 1");
        end
    endgenerate

    barrier_action_e          w_action;
    logic                     w_valid [DEPTH];
    logic [DATA_WIDTH-1:0]    w_data  [DEPTH];
    logic [c_OCC_WIDTH-1:0]   w_occupancy;
    logic [COUNTER_WIDTH-1:0] r_stallCount;
    logic [COUNTER_WIDTH-1:0] r_bubbleCount;

    assign w_action = decodeAction(bus.flush, bus.stall, bus.insertBubble);

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic                  prevValid;
            logic [DATA_WIDTH-1:0] prevData;

            if (i == 0) begin : g_head
                assign prevValid = bus.inValid;
                assign prevData  = bus.inData;
            end else begin : g_body
                assign prevValid = w_valid[i-1];
                assign prevData  = w_data[i-1];
            end

            barrier_stage #(
                .DATA_WIDTH   (DATA_WIDTH),
                .BUBBLE_VALUE (BUBBLE_VALUE),
                .IS_HEAD      (i == 0)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .action    (w_action),
                .prevValid (prevValid),
                .prevData  (prevData),
                .valid     (w_valid[i]),
                .data      (w_data[i])
            );
        end
    endgenerate

    // Popcount of registered valid bits only, so occupancy has no input-to-output path.
    always_comb begin
        w_occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occupancy = w_occupancy + c_OCC_WIDTH'(w_valid[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCount  <= '0;
            r_bubbleCount <= '0;
        end else begin
            if ((w_action == ACT_HOLD) && (r_stallCount != '1)) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
            if ((w_action == ACT_BUBBLE) && (r_bubbleCount != '1)) begin
                r_bubbleCount <= r_bubbleCount + 1'b1;
            end
        end
    end

    assign bus.outValid    = w_valid[DEPTH-1];
    assign bus.outData     = w_data[DEPTH-1];
    assign bus.occupancy   = w_occupancy;
    assign bus.stallCount  = r_stallCount;
    assign bus.bubbleCount = r_bubbleCount;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_barrier.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_barrier
// Brief    : Directed self-checking bench for pipeline_barrier (three configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_barrier;
    import pipeline_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;

    always #5 clk = ~clk;

    // A: DEPTH=3 W=32, NOP bubble.  B: DEPTH=1 W=8.  C: DEPTH=2 W=8, CW=2.
    pipeline_barrier_if #(.DATA_WIDTH(32), .DEPTH(3), .COUNTER_WIDTH(16)) busA ();
    pipeline_barrier_if #(.DATA_WIDTH(8),  .DEPTH(1), .COUNTER_WIDTH(16)) busB ();
    pipeline_barrier_if #(.DATA_WIDTH(8),  .DEPTH(2), .COUNTER_WIDTH(2))  busC ();

    pipeline_barrier #(.DATA_WIDTH(32), .DEPTH(3), .BUBBLE_VALUE(NOP_INSTRUCTION), .COUNTER_WIDTH(16))
        dutA (.clk(clk), .reset(reset), .bus(busA));
    pipeline_barrier #(.DATA_WIDTH(8), .DEPTH(1), .BUBBLE_VALUE(8'h00), .COUNTER_WIDTH(16))
        dutB (.clk(clk), .reset(reset), .bus(busB));
    pipeline_barrier #(.DATA_WIDTH(8), .DEPTH(2), .BUBBLE_VALUE(8'hEE), .COUNTER_WIDTH(2))
        dutC (.clk(clk), .reset(reset), .bus(busC));

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {busA.stall, busA.flush, busA.insertBubble, busA.inValid} = '0;
        {busB.stall, busB.flush, busB.insertBubble, busB.inValid} = '0;
        {busC.stall, busC.flush, busC.insertBubble, busC.inValid} = '0;
        busA.inData = '0;
        busB.inData = '0;
        busC.inData = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rstA_valid", 32'(busA.outValid), 32'd0);
        check("rstA_data",  busA.outData,       NOP_INSTRUCTION);
        check("rstA_occ",   32'(busA.occupancy), 32'd0);
        check("rstA_stall", 32'(busA.stallCount), 32'd0);
        check("rstC_data",  32'(busC.outData),  32'hEE);
        check("rstC_bub",   32'(busC.bubbleCount), 32'd0);

        // Streaming 1..4 through DEPTH=3
        busA.inValid = 1'b1;
        busA.inData = 32'd1; step();
        check("s1_occ1", 32'(busA.occupancy), 32'd1);
        check("s1_nv1",  32'(busA.outValid),  32'd0);
        busA.inData = 32'd2; step();
        check("s1_occ2", 32'(busA.occupancy), 32'd2);
        busA.inData = 32'd3; step();
        check("s1_out1", busA.outData, 32'd1);
        check("s1_v1",   32'(busA.outValid), 32'd1);
        check("s1_occ3", 32'(busA.occupancy), 32'd3);
        busA.inData = 32'd4; step();
        check("s1_out2", busA.outData, 32'd2);
        busA.inValid = 1'b0;
        busA.inData  = 32'd0; step();
        check("s1_out3", busA.outData, 32'd3);
        check("s1_occd2", 32'(busA.occupancy), 32'd2);
        step();
        check("s1_out4", busA.outData, 32'd4);
        check("s1_occd1", 32'(busA.occupancy), 32'd1);
        step();
        check("s1_drainV", 32'(busA.outValid), 32'd0);
        check("s1_drainD", busA.outData, 32'd0);
        check("s1_occ0",   32'(busA.occupancy), 32'd0);

        // DEPTH=1 stall hold
        busB.inValid = 1'b1;
        busB.inData  = 8'hA5; step();
        check("s2_load", 32'(busB.outData), 32'hA5);
        busB.stall  = 1'b1;
        busB.inData = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("s2_hold",  32'(busB.outData),  32'hA5);
            check("s2_holdV", 32'(busB.outValid), 32'd1);
            check("s2_cnt",   32'(busB.stallCount), 32'(k));
        end
        busB.stall   = 1'b0;
        busB.inValid = 1'b0; step();
        check("s2_invV", 32'(busB.outValid), 32'd0);
        check("s2_invD", 32'(busB.outData),  32'hFF);
        check("s2_occ",  32'(busB.occupancy), 32'd0);

        // DEPTH=2 bubble insertion: stage1=8, stage0=7
        busC.inValid = 1'b1;
        busC.inData = 8'd8; step();
        busC.inData = 8'd7; step();
        check("s4_pre", 32'(busC.outData), 32'd8);
        busC.insertBubble = 1'b1;
        busC.inData = 8'h55; step();
        check("s4_outV", 32'(busC.outValid), 32'd1);
        check("s4_outD", 32'(busC.outData),  32'd7);
        check("s4_occ",  32'(busC.occupancy), 32'd1);
        check("s4_bub",  32'(busC.bubbleCount), 32'd1);
        busC.insertBubble = 1'b0;
        busC.inValid = 1'b0;
        busC.inData = 8'h00; step();
        check("s4_nopV", 32'(busC.outValid), 32'd0);
        check("s4_nopD", 32'(busC.outData),  32'hEE);

        // Flush beats stall
        busC.inValid = 1'b1;
        busC.inData = 8'h11; step();
        busC.inData = 8'h22; step();
        check("s3_full", 32'(busC.occupancy), 32'd2);
        busC.flush = 1'b1;
        busC.stall = 1'b1;
        busC.inData = 8'h33; step();
        busC.flush = 1'b0;
        busC.stall = 1'b0;
        busC.inValid = 1'b0;
        check("s3_outV",  32'(busC.outValid),  32'd0);
        check("s3_occ",   32'(busC.occupancy), 32'd0);
        check("s3_outD",  32'(busC.outData),   32'hEE);
        check("s3_stall", 32'(busC.stallCount), 32'd0);
        check("s3_bub",   32'(busC.bubbleCount), 32'd1);

        // Saturation with 2-bit counters
        busC.stall = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("s5_sat", 32'(busC.stallCount), (k < 3) ? 32'(k) : 32'd3);
        end
        busC.insertBubble = 1'b1; step();
        check("s5_sbStall", 32'(busC.stallCount),  32'd3);
        check("s5_sbBub",   32'(busC.bubbleCount), 32'd1);
        busC.stall = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("s5_bubSat", 32'(busC.bubbleCount), (k < 2) ? 32'(1 + k) : 32'd3);
        end
        busC.insertBubble = 1'b0;

        // Async reset with DEPTH=3 full and non-zero counters
        busA.inValid = 1'b1;
        busA.inData = 32'h10; step();
        busA.inData = 32'h20; step();
        busA.inData = 32'h30; step();
        check("s6_full", 32'(busA.occupancy), 32'd3);
        busA.stall = 1'b1; step();
        check("s6_stallOut", busA.outData, 32'h10);
        busA.stall = 1'b0;
        busA.insertBubble = 1'b1; step();
        busA.insertBubble = 1'b0;
        check("s6_bubOut", busA.outData, 32'h20);
        check("s6_bubOcc", 32'(busA.occupancy), 32'd2);
        check("s6_cntS",   32'(busA.stallCount),  32'd1);
        check("s6_cntB",   32'(busA.bubbleCount), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("s6_rstV",   32'(busA.outValid),    32'd0);
        check("s6_rstD",   busA.outData,          NOP_INSTRUCTION);
        check("s6_rstOcc", 32'(busA.occupancy),   32'd0);
        check("s6_rstS",   32'(busA.stallCount),  32'd0);
        check("s6_rstB",   32'(busA.bubbleCount), 32'd0);
        check("s6_rstC",   32'(busC.stallCount),  32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
